// File: rtl/reg_release_if.sv
// Bundles the retire-side inputs and the free-list put group of reg_release.
interface reg_release_if #(
  parameter int NUM_PREGS = 64,
  parameter int TAG_WIDTH = 6,
  parameter int MAX_IO    = 3,
  parameter int BUF_DEPTH = 8
);
  logic [MAX_IO-1:0]             ret_valid;
  logic [MAX_IO-1:0]             ret_has_dest;
  logic [TAG_WIDTH-1:0]          ret_tag [MAX_IO];
  logic                          ret_ready;
  logic [$clog2(NUM_PREGS):0]    fl_len;
  logic [MAX_IO-1:0]             put_en;
  logic [TAG_WIDTH-1:0]          put [MAX_IO];
  logic [$clog2(BUF_DEPTH):0]    pending;
  logic                          dup_err;

  modport master (
    output ret_valid, ret_has_dest, ret_tag, fl_len,
    input  ret_ready, put_en, put, pending, dup_err
  );

  modport slave (
    input  ret_valid, ret_has_dest, ret_tag, fl_len,
    output ret_ready, put_en, put, pending, dup_err
  );
endinterface

// File: rtl/reg_release.sv
// Compacts stale tags from retiring instructions into a ring buffer and drains them into the free list.
// Define REG_RELEASE_DUPCHK_EN to drop double-freed tags and flag them on dup_err.
module reg_release #(
  parameter int NUM_PREGS = 64,
  parameter int TAG_WIDTH = 6,
  parameter int MAX_IO    = 3,
  parameter int BUF_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  reg_release_if.slave io
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NUM_PREGS) + 2;

  logic [TAG_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [MAX_IO-1:0]    r_put_en;
  logic [TAG_WIDTH-1:0] r_put [MAX_IO];

  logic                 w_ready;
  logic [CW-1:0]        w_free;
  logic [MAX_IO-1:0]    w_rel;
  logic [MAX_IO-1:0]    w_dup;
  logic [MAX_IO-1:0]    w_en;
  logic [CW-1:0]        w_off [MAX_IO];
  logic [CW-1:0]        w_acc;
  logic [CW-1:0]        w_k;
  logic [LW-1:0]        w_used;
  logic [LW-1:0]        w_room;

  assign w_free  = CW'(BUF_DEPTH) - r_count;
  assign w_ready = (w_free >= CW'(MAX_IO));

`ifdef REG_RELEASE_DUPCHK_EN
  logic [NUM_PREGS-1:0] r_bitmap;
  logic [NUM_PREGS-1:0] w_map_nxt;
  logic                 r_dup_err;

  // A tag is a duplicate if it is already held/driven, or repeats a lower slot of this group.
  always_comb begin
    w_dup = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      if (r_bitmap[io.ret_tag[i]]) w_dup[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (io.ret_valid[j] && io.ret_has_dest[j] && (io.ret_tag[j] == io.ret_tag[i]))
          w_dup[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_map_nxt = r_bitmap;
    for (int j = 0; j < MAX_IO; j++)
      if (r_put_en[j]) w_map_nxt[r_put[j]] = 1'b0;
    for (int i = 0; i < MAX_IO; i++)
      if (w_rel[i]) w_map_nxt[io.ret_tag[i]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitmap  <= '0;
      r_dup_err <= 1'b0;
    end else begin
      r_bitmap  <= w_map_nxt;
      r_dup_err <= w_ready && |(w_dup & io.ret_valid & io.ret_has_dest);
    end
  end

  assign io.dup_err = r_dup_err;
`else
  assign w_dup      = '0;
  assign io.dup_err = 1'b0;
`endif

  assign w_rel = io.ret_valid & io.ret_has_dest & ~w_dup & {MAX_IO{w_ready}};

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      w_off[i] = w_acc;
      w_acc    = w_acc + CW'(w_rel[i]);
    end
  end

  // The group on put lands in the free list at this edge, so it is not yet in fl_len.
  always_comb begin
    w_used = LW'(io.fl_len);
    for (int j = 0; j < MAX_IO; j++)
      w_used = w_used + LW'(r_put_en[j]);
    w_room = (w_used >= LW'(NUM_PREGS)) ? '0 : LW'(NUM_PREGS) - w_used;
    w_en   = '0;
    w_k    = '0;
    for (int j = 0; j < MAX_IO; j++) begin
      if ((CW'(j) < r_count) && (LW'(j) < w_room)) begin
        w_en[j] = 1'b1;
        w_k     = w_k + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_IO; i++)
      if (w_rel[i]) r_buf[r_tail + PW'(w_off[i])] <= io.ret_tag[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_put_en <= '0;
      for (int j = 0; j < MAX_IO; j++) r_put[j] <= '0;
    end else begin
      r_tail   <= r_tail + PW'(w_acc);
      r_head   <= r_head + PW'(w_k);
      r_count  <= r_count + w_acc - w_k;
      r_put_en <= w_en;
      for (int j = 0; j < MAX_IO; j++)
        r_put[j] <= w_en[j] ? r_buf[r_head + PW'(j)] : '0;
    end
  end

  assign io.ret_ready = w_ready;
  assign io.put_en    = r_put_en;
  assign io.pending   = r_count;
  always_comb begin
    for (int j = 0; j < MAX_IO; j++) io.put[j] = r_put[j];
  end
endmodule

// File: doc/reg_release.md
Name: reg_release

Overview:
- Return path into the physical-register free list.
- At commit, accepts up to MAX_IO retiring instructions per cycle. Each one can return a stale physical tag.
- Compacts the valid tags, holds them in a small circular buffer, and drives registered put_en/put groups into the free-list FIFO.
- Never lets the free-list length exceed NUM_PREGS.

Parameters:
- NUM_PREGS, 64, physical registers (free-list MAX_LENGTH).
- TAG_WIDTH, 6, tag width; equals $clog2(NUM_PREGS).
- MAX_IO, 3, retire width and put width.
- BUF_DEPTH, 8, staging buffer entries; power of two, >= 2*MAX_IO.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ret_valid  in  1 [MAX_IO]  retire slot i valid
- ret_has_dest  in  1 [MAX_IO]  slot i frees a tag
- ret_tag  in  TAG_WIDTH [MAX_IO]  stale tag of slot i
- ret_ready  out  1  group accepted this cycle
- fl_len  in  $clog2(NUM_PREGS)+1  current free-list length
- put_en  out  1 [MAX_IO]  to free-list put_en
- put  out  TAG_WIDTH [MAX_IO]  to free-list put
- pending  out  $clog2(BUF_DEPTH)+1  entries held in buffer
- dup_err  out  1  double-free pulse (optional feature)

Behaviour:
- Reset (async, rst high):
  - Buffer head, tail and count = 0.
  - All put_en = 0, all put = 0.
  - pending = 0, dup_err = 0.
  - The bitmap (optional feature) is cleared.
  - A reset mid-operation discards all buffered and in-flight tags.
- ret_ready: combinational, = (BUF_DEPTH - count) >= MAX_IO.
- Accept rule:
  - A slot counts as a release when ret_valid[i] && ret_has_dest[i] && ret_ready.
  - With ret_ready low, inputs are ignored and commit must hold them.
- Compaction:
  - Release slots are written at tail + prefix-sum offset of lower-index releases.
  - Slot order is preserved; gaps are removed.
  - tail advances by the release count, mod BUF_DEPTH.
- Drain, at every posedge:
  - inflight = popcount(put_en) of the currently driven group. The free list applies it at this same edge, so fl_len does not yet include it.
  - room = NUM_PREGS - fl_len - inflight, clamped at 0. Compute in $clog2(NUM_PREGS)+2 bits, no wrap.
  - k = min(count, MAX_IO, room).
  - Next put[j] = buf[head+j] and put_en[j] = 1 for j < k. For j >= k, put_en[j] = 0 and put[j] = 0.
  - head advances by k.
- Output group:
  - Always contiguous from slot 0.
  - Held for exactly one cycle, with no handshake back. The free list consumes every driven group.
- Latency:
  - Tag accepted at edge E0 is driven on put no earlier than after edge E1. That is 1 cycle in the buffer, 2 cycles from ret_valid to put_en.
  - There is no bypass from input to output.
- Simultaneous accept and drain: count_next = count + accepted - k. pending = count, registered.
- Boundaries:
  - Buffer full: ret_ready low.
  - Buffer empty: put_en all 0.
  - Free list full (fl_len == NUM_PREGS): k = 0.
  - head and tail wrap mod BUF_DEPTH.
  - fl_len > NUM_PREGS is illegal; room clamps to 0.

Optional Feature:
- Macro: REG_RELEASE_DUPCHK_EN.
- Defined:
  - An NUM_PREGS-bit bitmap marks tags currently held in the buffer or driven on put.
  - The bit is set on accept and cleared when the group carrying the tag leaves put.
  - An incoming tag whose bit is already set, or which repeats a tag from a lower slot of the same group, is dropped and does not occupy a buffer entry.
  - dup_err pulses high for 1 cycle, registered, in the cycle after the accept edge.
- Undefined: no bitmap; dup_err tied 0; every release is buffered.

Test Plan:
- Reset:
  - Assert rst asynchronously mid-cycle with 5 entries buffered -> put_en all 0 and pending = 0 immediately.
  - After release, ret_ready = 1.
- Latency:
  - fl_len = 10; single release of tag 7 in slot 1 at edge E0 -> after E1, put_en = {1,0,0} and put[0] = 7 for one cycle.
  - pending = 1 after E0, 0 after E1.
- Compaction:
  - ret_valid = {1,1,1}, ret_has_dest = {1,0,1}, tags {4,9,12} -> put = {4,12}, put_en = {1,1,0}.
- Free-list backpressure:
  - fl_len = 62 with 3 buffered -> group of 2.
  - Next cycle fl_len = 62 again (inflight 2) -> k = 0, no put.
  - After fl_len drops to 61 -> remaining 1 tag issued.
- Buffer full: hold fl_len = 64 and release 3 per cycle -> ret_ready drops once pending = 6, with BUF_DEPTH = 8.
- Double free (macro defined): release tag 5 twice in the same group -> one entry buffered, dup_err high for exactly 1 cycle.
